mem_wb_stage: RTL and testbench

- Memory-access and write-back stage of the RISC-V pipeline; sits between the EX stage and the register-file write port of decode.
- Issues loads and stores to data memory over a req/ack handshake, and aligns and sign-extends load data.
- Produces the single register-file write (enable/index/data) consumed by decode, and stalls the upstream pipeline while a memory access is outstanding.

---
 rtl/mem_wb_stage_pkg.sv | 24 ++
 rtl/mem_wb_stage_lsu_align.sv | 68 ++++++
 rtl/mem_wb_stage.sv | 158 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the memory-access / write-back stage.
// Write-back source select, load/store width codes and the stage state type.
package mem_wb_stage_pkg;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic is_mem_op(input logic mem_w_en, input logic [1:0] wb_sel);
        return mem_w_en | (wb_sel == WB_MEM);
    endfunction

endpackage

// File: rtl/mem_wb_stage_lsu_align.sv
// Byte-lane logic for the memory stage: store enables/data replication,
// load extraction with sign/zero extension, and misalignment detection.
module mem_wb_stage_lsu_align
    import mem_wb_stage_pkg::*;
(
    input  logic [2:0]  st_func3,
    input  logic [1:0]  st_addr,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    output logic        misaligned,
    input  logic [2:0]  ld_func3,
    input  logic [1:0]  ld_addr,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (st_func3)
            F3_B: begin
                st_be    = 4'b0001 << st_addr;
                st_wdata = {4{st_data[7:0]}};
            end
            F3_H: begin
                st_be    = st_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Byte accesses never fault; halves need even addresses; everything else is word-sized.
    always_comb begin
        misaligned = (st_addr != 2'b00);
        case (st_func3)
            F3_B, F3_BU: misaligned = 1'b0;
            F3_H, F3_HU: misaligned = st_addr[0];
            default:     ;
        endcase
    end

    always_comb begin
        case (ld_addr)
            2'd0:    byte_sel = ld_rdata[7:0];
            2'd1:    byte_sel = ld_rdata[15:8];
            2'd2:    byte_sel = ld_rdata[23:16];
            default: byte_sel = ld_rdata[31:24];
        endcase
        half_sel = ld_addr[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    end

    always_comb begin
        ld_data = ld_rdata;
        case (ld_func3)
            F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   ld_data = {24'b0, byte_sel};
            F3_HU:   ld_data = {16'b0, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// RISC-V memory-access / write-back stage: issues data-memory req/ack accesses,
// aligns load data and drives the single register-file write port.
//
// state | meaning
// IDLE  | accepting a new instruction every cycle
// BUSY  | memory access outstanding, upstream stalled, waiting for ack or timeout
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_reg2,
    input  logic [31:0] i_pc4,
    input  logic [2:0]  i_func3,
    input  logic        i_mem_w_en,
    input  logic [1:0]  i_wb_sel,
    input  logic        i_wb_en,
    input  logic [4:0]  i_w_idx,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_wr_en,
    output logic [4:0]  o_wr_idx,
    output logic [31:0] o_wr_data,
    output logic        o_misaligned,
    output logic        o_bus_err
);

    localparam bit TO_EN = (TIMEOUT_CYC > 0);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = TO_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [2:0]       lat_func3;
    logic [1:0]       lat_addr;
    logic [4:0]       lat_rd;
    logic             lat_wb_en;
    logic             lat_we;

    logic             mem_op;
    logic             misaligned;
    logic             expire;
    logic [3:0]       st_be;
    logic [31:0]      st_wdata;
    logic [31:0]      ld_data;

    mem_wb_stage_lsu_align u_align (
        .st_func3   (i_func3),
        .st_addr    (i_alu_result[1:0]),
        .st_data    (i_reg2),
        .st_be      (st_be),
        .st_wdata   (st_wdata),
        .misaligned (misaligned),
        .ld_func3   (lat_func3),
        .ld_addr    (lat_addr),
        .ld_rdata   (i_dmem_rdata),
        .ld_data    (ld_data)
    );

    assign mem_op  = is_mem_op(i_mem_w_en, i_wb_sel);
    // Down-counter hits zero on the last permitted wait cycle; ack in that cycle still wins.
    assign expire  = TO_EN && (wait_cnt == '0);
    assign o_stall = (state == BUSY);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mem_op && !misaligned) state_nxt = BUSY;
            BUSY:    if (i_dmem_ack || expire)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            lat_func3    <= '0;
            lat_addr     <= '0;
            lat_rd       <= '0;
            lat_wb_en    <= 1'b0;
            lat_we       <= 1'b0;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_wdata <= '0;
            o_dmem_be    <= '0;
            o_wr_en      <= 1'b0;
            o_wr_idx     <= '0;
            o_wr_data    <= '0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
        end else begin
            state        <= state_nxt;
            o_wr_en      <= 1'b0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        if (misaligned) begin
                            o_misaligned <= 1'b1;
                        end else begin
                            lat_func3    <= i_func3;
                            lat_addr     <= i_alu_result[1:0];
                            lat_rd       <= i_w_idx;
                            lat_wb_en    <= i_wb_en;
                            lat_we       <= i_mem_w_en;
                            wait_cnt     <= CNT_LOAD;
                            o_dmem_req   <= 1'b1;
                            o_dmem_we    <= i_mem_w_en;
                            o_dmem_addr  <= {i_alu_result[31:2], 2'b00};
                            o_dmem_wdata <= i_mem_w_en ? st_wdata : 32'b0;
                            o_dmem_be    <= i_mem_w_en ? st_be : 4'b1111;
                        end
                    end else begin
                        o_wr_en   <= i_wb_en && (i_w_idx != 5'd0);
                        o_wr_idx  <= i_w_idx;
                        o_wr_data <= (i_wb_sel == WB_PC4) ? i_pc4 : i_alu_result;
                    end
                end
                BUSY: begin
                    if (i_dmem_ack || expire) begin
                        o_dmem_req   <= 1'b0;
                        o_dmem_we    <= 1'b0;
                        o_dmem_addr  <= '0;
                        o_dmem_wdata <= '0;
                        o_dmem_be    <= '0;
                        if (i_dmem_ack) begin
                            if (!lat_we) begin
                                o_wr_en   <= lat_wb_en && (lat_rd != 5'd0);
                                o_wr_idx  <= lat_rd;
                                o_wr_data <= ld_data;
                            end
                        end else begin
                            o_bus_err <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected register writes are queued at issue
// and compared whenever the stage pulses its write port.
`timescale 1ns/1ps
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_alu_result, i_reg2, i_pc4;
    logic [2:0]  i_func3;
    logic        i_mem_w_en, i_wb_en;
    logic [1:0]  i_wb_sel;
    logic [4:0]  i_w_idx;
    logic        o_stall, o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic        o_wr_en;
    logic [4:0]  o_wr_idx;
    logic [31:0] o_wr_data;
    logic        o_misaligned, o_bus_err;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } wb_t;

    wb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    mem_wb_stage #(.TIMEOUT_CYC(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_alu_result (i_alu_result),
        .i_reg2       (i_reg2),
        .i_pc4        (i_pc4),
        .i_func3      (i_func3),
        .i_mem_w_en   (i_mem_w_en),
        .i_wb_sel     (i_wb_sel),
        .i_wb_en      (i_wb_en),
        .i_w_idx      (i_w_idx),
        .o_stall      (o_stall),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_we    (o_dmem_we),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_wdata (o_dmem_wdata),
        .o_dmem_be    (o_dmem_be),
        .i_dmem_ack   (i_dmem_ack),
        .i_dmem_rdata (i_dmem_rdata),
        .o_wr_en      (o_wr_en),
        .o_wr_idx     (o_wr_idx),
        .o_wr_data    (o_wr_data),
        .o_misaligned (o_misaligned),
        .o_bus_err    (o_bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * lo));
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return w;
        endcase
    endfunction

    task automatic push_wb(input logic [4:0] idx, input logic [31:0] data);
        wb_t e;
        e.idx  = idx;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        i_alu_result = 32'h0;
        i_reg2       = 32'h0;
        i_pc4        = 32'h0;
        i_func3      = 3'b000;
        i_mem_w_en   = 1'b0;
        i_wb_sel     = 2'b00;
        i_wb_en      = 1'b0;
        i_w_idx      = 5'd0;
    endtask

    task automatic drive_alu(input logic [31:0] alu, input logic [31:0] pc4,
                             input logic [1:0] sel, input logic [4:0] rd);
        i_alu_result = alu;
        i_pc4        = pc4;
        i_wb_sel     = sel;
        i_wb_en      = 1'b1;
        i_w_idx      = rd;
        i_mem_w_en   = 1'b0;
    endtask

    task automatic drive_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd);
        i_alu_result = addr;
        i_func3      = f3;
        i_wb_sel     = 2'b01;
        i_wb_en      = 1'b1;
        i_w_idx      = rd;
        i_mem_w_en   = 1'b0;
    endtask

    // Ack is raised during the last of 'waits' request cycles.
    task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] rdata, input int waits);
        drive_load(addr, f3, rd);
        if (rd != 5'd0) push_wb(rd, exp_load(f3, addr[1:0], rdata));
        step();
        bubble();
        chk("ld_req", {31'b0, o_dmem_req}, 32'd1);
        chk("ld_we", {31'b0, o_dmem_we}, 32'd0);
        chk("ld_addr", o_dmem_addr, {addr[31:2], 2'b00});
        chk("ld_stall", {31'b0, o_stall}, 32'd1);
        for (int i = 1; i < waits; i++) begin
            step();
            chk("ld_hold", {30'b0, o_dmem_req, o_stall}, 32'd3);
        end
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = rdata;
        step();
        i_dmem_ack   = 1'b0;
        i_dmem_rdata = 32'h5555_AAAA;
        chk("ld_done", {29'b0, o_dmem_req, o_stall, o_bus_err}, 32'd0);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] data,
                            input logic [3:0] be, input logic [31:0] wdata);
        i_alu_result = addr;
        i_func3      = f3;
        i_reg2       = data;
        i_mem_w_en   = 1'b1;
        i_wb_sel     = 2'b00;
        i_wb_en      = 1'b0;
        i_w_idx      = 5'd0;
        step();
        bubble();
        chk("st_req_we", {30'b0, o_dmem_req, o_dmem_we}, 32'd3);
        chk("st_addr", o_dmem_addr, {addr[31:2], 2'b00});
        chk("st_be", {28'b0, o_dmem_be}, {28'b0, be});
        chk("st_wdata", o_dmem_wdata, wdata);
        i_dmem_ack = 1'b1;
        step();
        i_dmem_ack = 1'b0;
        chk("st_done", {30'b0, o_dmem_req, o_stall}, 32'd0);
    endtask

    always @(negedge clk) begin : monitor
        wb_t e;
        if (!rst && o_wr_en) begin
            if (sb_q.size() == 0) begin
                chk("wr_unexp", {31'b0, o_wr_en}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("wr_idx", {27'b0, o_wr_idx}, {27'b0, e.idx});
                chk("wr_data", o_wr_data, e.data);
            end
        end
    end

    initial begin
        rst          = 1'b1;
        i_dmem_ack   = 1'b0;
        i_dmem_rdata = 32'h0;
        bubble();
        step();
        step();
        chk("rst_ctl", {22'b0, o_stall, o_dmem_req, o_dmem_we, o_dmem_be, o_wr_en,
                        o_misaligned, o_bus_err}, 32'd0);
        chk("rst_addr", o_dmem_addr, 32'd0);
        chk("rst_wdata", o_dmem_wdata, 32'd0);
        chk("rst_wr", o_wr_data | {27'b0, o_wr_idx}, 32'd0);
        rst = 1'b0;

        drive_alu(32'h0000_1234, 32'h0, 2'b00, 5'd5);
        push_wb(5'd5, 32'h0000_1234);
        step();
        drive_alu(32'h0000_9999, 32'h0, 2'b00, 5'd0);
        step();
        chk("alu_rd0", {31'b0, o_wr_en}, 32'd0);
        drive_alu(32'h1111_0000, 32'h0000_0404, 2'b10, 5'd1);
        push_wb(5'd1, 32'h0000_0404);
        step();
        bubble();
        step();

        do_load(32'h0000_0103, 3'b000, 5'd2, 32'h80FF_0000, 3);
        do_load(32'h0000_0103, 3'b100, 5'd3, 32'h80FF_0000, 1);
        do_load(32'h0000_0102, 3'b001, 5'd4, 32'h80FF_0000, 2);
        do_load(32'h0000_0100, 3'b101, 5'd5, 32'h1234_F00D, 1);
        do_load(32'h0000_0101, 3'b000, 5'd6, 32'h0000_7F00, 1);
        do_load(32'h0000_0104, 3'b010, 5'd7, 32'hCAFE_BABE, 2);
        do_load(32'h0000_0108, 3'b010, 5'd0, 32'h0BAD_F00D, 1);

        do_store(32'h0000_0206, 3'b001, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD);
        do_store(32'h0000_0301, 3'b000, 32'h0000_005A, 4'b0010, 32'h5A5A_5A5A);
        do_store(32'h0000_0400, 3'b010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

        drive_load(32'h0000_0101, 3'b010, 5'd3);
        step();
        bubble();
        chk("mis_pulse", {29'b0, o_misaligned, o_dmem_req, o_stall}, 32'd4);
        step();
        chk("mis_clear", {29'b0, o_misaligned, o_dmem_req, o_stall}, 32'd0);
        drive_load(32'h0000_0203, 3'b001, 5'd3);
        step();
        bubble();
        chk("mis_half", {29'b0, o_misaligned, o_dmem_req, o_stall}, 32'd4);
        step();

        drive_load(32'h0000_0500, 3'b010, 5'd4);
        step();
        bubble();
        chk("to_req", {30'b0, o_dmem_req, o_stall}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_hold", {29'b0, o_dmem_req, o_stall, o_bus_err}, 32'd6);
        end
        step();
        chk("to_err", {29'b0, o_dmem_req, o_stall, o_bus_err}, 32'd1);
        step();
        chk("to_err_clr", {31'b0, o_bus_err}, 32'd0);
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'h1234_5678;
        step();
        i_dmem_ack = 1'b0;
        chk("late_ack", {30'b0, o_dmem_req, o_stall}, 32'd0);
        step();

        do_load(32'h0000_0504, 3'b010, 5'd6, 32'h1357_9BDF, 4);

        drive_load(32'h0000_0600, 3'b001, 5'd8);
        push_wb(5'd8, exp_load(3'b001, 2'b00, 32'hFFFF_8001));
        step();
        drive_alu(32'h0000_CAFE, 32'h0, 2'b00, 5'd9);
        push_wb(5'd9, 32'h0000_CAFE);
        chk("b2b_stall", {31'b0, o_stall}, 32'd1);
        step();
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'hFFFF_8001;
        step();
        i_dmem_ack = 1'b0;
        chk("b2b_release", {31'b0, o_stall}, 32'd0);
        step();
        bubble();
        step();

        drive_load(32'h0000_0700, 3'b010, 5'd10);
        step();
        bubble();
        chk("rb_req", {31'b0, o_dmem_req}, 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rb_ctl", {22'b0, o_stall, o_dmem_req, o_dmem_we, o_dmem_be, o_wr_en,
                       o_misaligned, o_bus_err}, 32'd0);
        chk("rb_addr", o_dmem_addr, 32'd0);
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'hFFFF_FFFF;
        step();
        i_dmem_ack = 1'b0;
        chk("rb_ack_ign", {30'b0, o_dmem_req, o_stall}, 32'd0);
        drive_alu(32'h0000_0077, 32'h0, 2'b00, 5'd7);
        push_wb(5'd7, 32'h0000_0077);
        step();
        bubble();

        for (int i = 0; i < 3; i++) step();
        chk("sb_left", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
